// File: rtl/max3421e_pkg.sv
// Shared types and constants for the MAX3421E SPI master: FSM states,
// register numbers and command-byte helpers.
package max3421e_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_WAIT_WDATA,
        ST_HOLD,
        ST_GAP
    } state_t;

    localparam logic [4:0] REG_RCVFIFO = 5'd1;
    localparam logic [4:0] REG_SNDFIFO = 5'd2;
    localparam logic [4:0] REG_SUDFIFO = 5'd4;
    localparam logic [4:0] REG_USBIRQ  = 5'd13;
    localparam logic [4:0] REG_USBCTL  = 5'd15;
    localparam logic [4:0] REG_PINCTL  = 5'd17;
    localparam logic [4:0] REG_REVISION = 5'd18;
    localparam logic [4:0] REG_HIRQ    = 5'd25;

    localparam logic [3:0] MAX_LEN = 4'd8;

    function automatic logic [7:0] cmd_byte(input logic [4:0] regn, input logic wr);
        return {regn, 1'b0, wr, 1'b0};
    endfunction

    function automatic logic [3:0] clamp_len(input logic [3:0] len);
        return (len > MAX_LEN) ? MAX_LEN : len;
    endfunction

endpackage

// File: rtl/max3421e_spi_master_clk_gen.sv
// SCLK generator: counts CLK_DIV clocks per half-period and emits one-cycle
// rise/fall strobes; held idle (SCLK low, counter cleared) while disabled.
module spi_clk_gen #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk_in,
    input  logic n_rst_in,
    input  logic en_in,
    output logic rise_out,
    output logic fall_out,
    output logic sclk_out
);

    localparam logic [7:0] LP_DIV_M1 = 8'(CLK_DIV - 1);

    logic [7:0] r_cnt;
    logic       r_phase;
    logic       w_tick;

    assign w_tick   = en_in && (r_cnt == LP_DIV_M1);
    assign rise_out = w_tick && !r_phase;
    assign fall_out = w_tick && r_phase;
    assign sclk_out = r_phase;

    always_ff @(posedge clk_in or negedge n_rst_in) begin
        if (!n_rst_in) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (!en_in) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (w_tick) begin
            r_cnt   <= '0;
            r_phase <= !r_phase;
        end else begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/max3421e_spi_master.sv
// SPI mode-0 master for the MAX3421E: one command byte (status clocked back)
// followed by up to 8 register data bytes, read or write.
module max3421e_spi_master
    import max3421e_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic       clk_in,
    input  logic       n_rst_in,
    input  logic       req_valid_in,
    output logic       req_ready_out,
    input  logic [4:0] reg_in,
    input  logic       write_in,
    input  logic [3:0] len_in,
    input  logic [7:0] wdata_in,
    input  logic       wdata_valid_in,
    output logic       wdata_ready_out,
    output logic [7:0] rdata_out,
    output logic       rdata_valid_out,
    output logic [7:0] status_out,
    output logic       status_valid_out,
    output logic       busy_out,
    output logic       n_ss_out,
    output logic       mosi_out,
    output logic       sclk_out,
    input  logic       miso_in
);

    localparam logic [8:0] LP_HOLD_M1 = 9'(CLK_DIV - 1);
    localparam logic [8:0] LP_GAP_M1  = 9'(2 * CLK_DIV - 1);

    state_t     r_state;
    logic       r_ready;
    logic       r_busy;
    logic       r_nss;
    logic [7:0] r_sh;
    logic [6:0] r_rx;
    logic [2:0] r_bit;
    logic [3:0] r_bytes;
    logic       r_cmd;
    logic       r_write;
    logic       r_wready;
    logic [7:0] r_wbuf;
    logic       r_wgot;
    logic [8:0] r_cnt;
    logic [7:0] r_rdata;
    logic       r_rdata_valid;
    logic [7:0] r_status;
    logic       r_status_valid;

    logic       w_gen_en;
    logic       w_rise;
    logic       w_fall;
    logic       w_wtake;
    logic       w_wavail;
    logic [7:0] w_wbyte;
    logic [7:0] w_rx_byte;

    assign w_gen_en  = (r_state == ST_SETUP) || (r_state == ST_SHIFT);
    assign w_wtake   = r_wready && wdata_valid_in;
    assign w_wavail  = w_wtake || r_wgot;
    assign w_wbyte   = w_wtake ? wdata_in : r_wbuf;
    assign w_rx_byte = {r_rx, miso_in};

    spi_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk_in   (clk_in),
        .n_rst_in (n_rst_in),
        .en_in    (w_gen_en),
        .rise_out (w_rise),
        .fall_out (w_fall),
        .sclk_out (sclk_out)
    );

    always_ff @(posedge clk_in or negedge n_rst_in) begin
        if (!n_rst_in) begin
            r_state        <= ST_IDLE;
            r_ready        <= 1'b0;
            r_busy         <= 1'b0;
            r_nss          <= 1'b1;
            r_sh           <= '0;
            r_rx           <= '0;
            r_bit          <= '0;
            r_bytes        <= '0;
            r_cmd          <= 1'b0;
            r_write        <= 1'b0;
            r_wready       <= 1'b0;
            r_wbuf         <= '0;
            r_wgot         <= 1'b0;
            r_cnt          <= '0;
            r_rdata        <= '0;
            r_rdata_valid  <= 1'b0;
            r_status       <= '0;
            r_status_valid <= 1'b0;
        end else begin
            r_rdata_valid  <= 1'b0;
            r_status_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!r_ready) begin
                        r_ready <= 1'b1;
                    end else if (req_valid_in) begin
                        r_state <= ST_SETUP;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_nss   <= 1'b0;
                        r_sh    <= cmd_byte(reg_in, write_in);
                        r_bit   <= '0;
                        r_bytes <= clamp_len(len_in);
                        r_cmd   <= 1'b1;
                        r_write <= write_in;
                        r_wgot  <= 1'b0;
                    end
                end
                ST_SETUP, ST_SHIFT: begin
                    // Write data may arrive at any point while ready is up; park it.
                    if (w_wtake) begin
                        r_wbuf   <= wdata_in;
                        r_wgot   <= 1'b1;
                        r_wready <= 1'b0;
                    end
                    if (w_rise) begin
                        r_rx    <= w_rx_byte[6:0];
                        r_state <= ST_SHIFT;
                        if (r_bit == 3'd7) begin
                            if (r_cmd) begin
                                r_status       <= w_rx_byte;
                                r_status_valid <= 1'b1;
                            end else if (!r_write) begin
                                r_rdata       <= w_rx_byte;
                                r_rdata_valid <= 1'b1;
                            end
                            if (r_write && (r_bytes != 4'd0)) begin
                                r_wready <= 1'b1;
                            end
                        end
                    end
                    if (w_fall) begin
                        r_bit <= r_bit + 3'd1;
                        if (r_bit != 3'd7) begin
                            r_sh <= {r_sh[6:0], 1'b0};
                        end else if (r_bytes == 4'd0) begin
                            r_state <= ST_HOLD;
                            r_sh    <= '0;
                            r_cnt   <= LP_HOLD_M1;
                        end else begin
                            r_bytes <= r_bytes - 4'd1;
                            r_cmd   <= 1'b0;
                            if (!r_write) begin
                                r_sh <= '0;
                            end else if (w_wavail) begin
                                r_sh     <= w_wbyte;
                                r_wgot   <= 1'b0;
                                r_wready <= 1'b0;
                            end else begin
                                r_sh    <= '0;
                                r_state <= ST_WAIT_WDATA;
                            end
                        end
                    end
                end
                ST_WAIT_WDATA: begin
                    // Clock generator is disabled here, so SCLK stays low until data shows up.
                    if (w_wtake) begin
                        r_sh     <= wdata_in;
                        r_wready <= 1'b0;
                        r_state  <= ST_SHIFT;
                    end
                end
                ST_HOLD: begin
                    if (r_cnt == 9'd0) begin
                        r_state <= ST_GAP;
                        r_nss   <= 1'b1;
                        r_cnt   <= LP_GAP_M1;
                    end else begin
                        r_cnt <= r_cnt - 9'd1;
                    end
                end
                ST_GAP: begin
                    if (r_cnt == 9'd0) begin
                        r_state <= ST_IDLE;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 9'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready_out    = r_ready;
    assign busy_out         = r_busy;
    assign n_ss_out         = r_nss;
    assign mosi_out         = r_sh[7];
    assign wdata_ready_out  = r_wready;
    assign rdata_out        = r_rdata;
    assign rdata_valid_out  = r_rdata_valid;
    assign status_out       = r_status;
    assign status_valid_out = r_status_valid;

endmodule

// File: tb/tb_max3421e_spi_master.sv
// Directed bench for max3421e_spi_master: a MISO slave model plus a pin monitor
// collecting MOSI bytes, SCLK pulse counts/periods and n_ss gaps.
module tb_max3421e_spi_master;
    import max3421e_pkg::*;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       req_valid;
    logic       req_ready;
    logic [4:0] reg_num;
    logic       write_en;
    logic [3:0] len;
    logic [7:0] wdata;
    logic       wdata_valid;
    logic       wdata_ready;
    logic [7:0] rdata;
    logic       rdata_valid;
    logic [7:0] status;
    logic       status_valid;
    logic       busy;
    logic       n_ss;
    logic       mosi;
    logic       sclk;
    logic       miso;

    int checks = 0;
    int failures = 0;

    int pulses, nss_viol, nss_falls, nss_high_run, gap_last;
    int per_min, per_max, since_rise, bitpos, mon_bits;
    logic [7:0] mon_byte;
    logic prev_sclk, prev_nss;
    logic [7:0] mosi_q[$];
    logic [7:0] rdata_q[$];
    logic [7:0] status_q[$];
    logic [7:0] slave_tx [16];

    max3421e_spi_master #(.CLK_DIV(2)) dut (
        .clk_in           (clk),
        .n_rst_in         (n_rst),
        .req_valid_in     (req_valid),
        .req_ready_out    (req_ready),
        .reg_in           (reg_num),
        .write_in         (write_en),
        .len_in           (len),
        .wdata_in         (wdata),
        .wdata_valid_in   (wdata_valid),
        .wdata_ready_out  (wdata_ready),
        .rdata_out        (rdata),
        .rdata_valid_out  (rdata_valid),
        .status_out       (status),
        .status_valid_out (status_valid),
        .busy_out         (busy),
        .n_ss_out         (n_ss),
        .mosi_out         (mosi),
        .sclk_out         (sclk),
        .miso_in          (miso)
    );

    always #5 clk = ~clk;

    // Pin monitor and slave model, sampled on the inactive clock edge.
    always @(negedge clk) begin
        if (!n_rst) begin
            prev_sclk = 1'b0;
            prev_nss = 1'b1;
            bitpos = 0;
            mon_bits = 0;
            since_rise = -1;
            miso = 1'b0;
        end else begin
            if (prev_nss && !n_ss) begin
                gap_last = nss_high_run;
                nss_falls++;
                bitpos = 0;
                mon_bits = 0;
                since_rise = -1;
            end
            if (n_ss) nss_high_run++; else nss_high_run = 0;
            if (!prev_sclk && sclk) begin
                pulses++;
                mon_byte = {mon_byte[6:0], mosi};
                mon_bits++;
                if (mon_bits == 8) begin
                    mosi_q.push_back(mon_byte);
                    mon_bits = 0;
                end
                if (since_rise > 0) begin
                    if (since_rise < per_min) per_min = since_rise;
                    if (since_rise > per_max) per_max = since_rise;
                end
                since_rise = 0;
            end
            if (since_rise >= 0) since_rise++;
            if (prev_sclk && !sclk) bitpos++;
            if (sclk && n_ss) nss_viol++;
            if (rdata_valid) rdata_q.push_back(rdata);
            if (status_valid) status_q.push_back(status);
            miso = n_ss ? 1'b0 : slave_tx[(bitpos >> 3) & 15][7 - (bitpos & 7)];
            prev_sclk = sclk;
            prev_nss = n_ss;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        pulses = 0;
        nss_viol = 0;
        nss_falls = 0;
        gap_last = 0;
        per_min = 1000;
        per_max = 0;
        mosi_q.delete();
        rdata_q.delete();
        status_q.delete();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic [4:0] r, input logic w, input logic [3:0] l);
        int n = 0;
        while (!req_ready && n < 1000) begin
            step();
            n++;
        end
        chk("req_ready_timeout", {31'd0, req_ready}, 32'd1);
        reg_num = r;
        write_en = w;
        len = l;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        reg_num = 5'h1F;
        write_en = ~w;
        len = 4'hF;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (!req_ready && n < 3000) begin
            step();
            n++;
        end
        chk(tag, {31'd0, req_ready}, 32'd1);
    endtask

    task automatic wait_wready();
        int n = 0;
        while (!wdata_ready && n < 1000) begin
            step();
            n++;
        end
        chk("wready_timeout", {31'd0, wdata_ready}, 32'd1);
    endtask

    initial begin
        int n;
        int bad;
        int frozen;
        n_rst = 1'b0;
        req_valid = 1'b0;
        reg_num = '0;
        write_en = 1'b0;
        len = '0;
        wdata = '0;
        wdata_valid = 1'b0;
        nss_high_run = 0;
        mon_byte = '0;
        for (int i = 0; i < 16; i++) slave_tx[i] = 8'h00;
        clear_mon();
        repeat (3) step();

        // Reset values
        chk("rst_nss", {31'd0, n_ss}, 32'd1);
        chk("rst_sclk", {31'd0, sclk}, 32'd0);
        chk("rst_mosi", {31'd0, mosi}, 32'd0);
        chk("rst_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_wready", {31'd0, wdata_ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_valids", {30'd0, rdata_valid, status_valid}, 32'd0);
        chk("rst_data", {16'd0, rdata, status}, 32'd0);
        n_rst = 1'b1;
        #1;
        chk("rel_ready_before_edge", {31'd0, req_ready}, 32'd0);
        step();
        chk("rel_ready_first_clk", {31'd0, req_ready}, 32'd1);
        chk("rel_busy", {31'd0, busy}, 32'd0);

        // Write PINCTL, one byte 0x18
        clear_mon();
        wdata = 8'h18;
        wdata_valid = 1'b1;
        do_req(REG_PINCTL, 1'b1, 4'd1);
        chk("wr_busy", {31'd0, busy}, 32'd1);
        chk("wr_ready_low", {31'd0, req_ready}, 32'd0);
        wait_idle("wr_idle_timeout");
        wdata_valid = 1'b0;
        chk("wr_nbytes", mosi_q.size(), 32'd2);
        chk("wr_cmd", {24'd0, (mosi_q.size() > 0) ? mosi_q[0] : 8'hxx}, 32'h8A);
        chk("wr_data", {24'd0, (mosi_q.size() > 1) ? mosi_q[1] : 8'hxx}, 32'h18);
        chk("wr_pulses", pulses, 32'd16);
        chk("wr_per_min", per_min, 32'd4);
        chk("wr_per_max", per_max, 32'd4);
        chk("wr_nss_viol", nss_viol, 32'd0);
        chk("wr_status_cnt", status_q.size(), 32'd1);
        chk("wr_rdata_cnt", rdata_q.size(), 32'd0);

        // Read RCVFIFO, three bytes
        clear_mon();
        slave_tx[0] = 8'h5A;
        slave_tx[1] = 8'h11;
        slave_tx[2] = 8'h22;
        slave_tx[3] = 8'h33;
        do_req(REG_RCVFIFO, 1'b0, 4'd3);
        wait_idle("rd_idle_timeout");
        chk("rd_cmd", {24'd0, (mosi_q.size() > 0) ? mosi_q[0] : 8'hxx}, 32'h08);
        chk("rd_mosi_zero", {24'd0, (mosi_q.size() > 3) ? (mosi_q[1] | mosi_q[2] | mosi_q[3]) : 8'hxx}, 32'h00);
        chk("rd_status", {24'd0, (status_q.size() > 0) ? status_q[0] : 8'hxx}, 32'h5A);
        chk("rd_rdata_cnt", rdata_q.size(), 32'd3);
        chk("rd_rdata0", {24'd0, (rdata_q.size() > 0) ? rdata_q[0] : 8'hxx}, 32'h11);
        chk("rd_rdata1", {24'd0, (rdata_q.size() > 1) ? rdata_q[1] : 8'hxx}, 32'h22);
        chk("rd_rdata2", {24'd0, (rdata_q.size() > 2) ? rdata_q[2] : 8'hxx}, 32'h33);
        chk("rd_pulses", pulses, 32'd32);

        // Write two bytes to SNDFIFO, second byte withheld for 50 cycles
        clear_mon();
        do_req(REG_SNDFIFO, 1'b1, 4'd2);
        wait_wready();
        wdata = 8'hA5;
        wdata_valid = 1'b1;
        step();
        wdata_valid = 1'b0;
        wdata = 8'h00;
        wait_wready();
        repeat (4) step();
        frozen = pulses;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            if (sclk !== 1'b0 || n_ss !== 1'b0 || wdata_ready !== 1'b1) bad++;
            step();
        end
        chk("wait_frozen_pins", bad, 32'd0);
        chk("wait_pulses_before", frozen, 32'd16);
        chk("wait_pulses_held", pulses, 32'd16);
        wdata = 8'h3C;
        wdata_valid = 1'b1;
        step();
        wdata_valid = 1'b0;
        wait_idle("wait_idle_timeout");
        chk("wait_cmd", {24'd0, (mosi_q.size() > 0) ? mosi_q[0] : 8'hxx}, 32'h12);
        chk("wait_byte1", {24'd0, (mosi_q.size() > 1) ? mosi_q[1] : 8'hxx}, 32'hA5);
        chk("wait_byte2", {24'd0, (mosi_q.size() > 2) ? mosi_q[2] : 8'hxx}, 32'h3C);
        chk("wait_pulses", pulses, 32'd24);

        // Status poll (len 0) on HIRQ
        clear_mon();
        slave_tx[0] = 8'hC3;
        do_req(REG_HIRQ, 1'b0, 4'd0);
        wait_idle("poll_idle_timeout");
        chk("poll_pulses", pulses, 32'd8);
        chk("poll_cmd", {24'd0, (mosi_q.size() > 0) ? mosi_q[0] : 8'hxx}, 32'hC8);
        chk("poll_status_cnt", status_q.size(), 32'd1);
        chk("poll_status", {24'd0, (status_q.size() > 0) ? status_q[0] : 8'hxx}, 32'hC3);
        chk("poll_rdata_cnt", rdata_q.size(), 32'd0);

        // len 12 clamps to 8 data bytes
        clear_mon();
        for (int i = 0; i < 16; i++) slave_tx[i] = 8'(8'hC0 + i);
        do_req(REG_RCVFIFO, 1'b0, 4'd12);
        wait_idle("clamp_idle_timeout");
        chk("clamp_pulses", pulses, 32'd72);
        chk("clamp_rdata_cnt", rdata_q.size(), 32'd8);
        chk("clamp_last", {24'd0, (rdata_q.size() > 7) ? rdata_q[7] : 8'hxx}, 32'hC8);

        // Reset during bit 4 of the first data byte
        clear_mon();
        do_req(REG_RCVFIFO, 1'b0, 4'd2);
        n = 0;
        while (pulses < 13 && n < 1000) begin
            step();
            n++;
        end
        chk("abort_reach_bit4", pulses, 32'd13);
        chk("abort_sclk_high", {31'd0, sclk}, 32'd1);
        n_rst = 1'b0;
        #1;
        chk("abort_nss", {31'd0, n_ss}, 32'd1);
        chk("abort_sclk", {31'd0, sclk}, 32'd0);
        repeat (3) step();
        n_rst = 1'b1;
        repeat (10) step();
        chk("abort_no_rdata", rdata_q.size(), 32'd0);
        chk("abort_status_cnt", status_q.size(), 32'd1);
        clear_mon();
        slave_tx[0] = 8'h96;
        do_req(REG_HIRQ, 1'b0, 4'd0);
        wait_idle("abort_idle_timeout");
        chk("abort_new_pulses", pulses, 32'd8);
        chk("abort_new_status", {24'd0, (status_q.size() > 0) ? status_q[0] : 8'hxx}, 32'h96);

        // Back-to-back requests with valid held high
        clear_mon();
        reg_num = REG_USBIRQ;
        write_en = 1'b0;
        len = 4'd0;
        req_valid = 1'b1;
        n = 0;
        while (nss_falls < 2 && n < 2000) begin
            step();
            n++;
        end
        req_valid = 1'b0;
        wait_idle("b2b_idle_timeout");
        chk("b2b_falls", nss_falls, 32'd2);
        chk("b2b_gap_ge4", {31'd0, (gap_last >= 4)}, 32'd1);
        chk("b2b_pulses", pulses, 32'd16);
        chk("b2b_cmd", {24'd0, (mosi_q.size() > 1) ? mosi_q[1] : 8'hxx}, 32'h68);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/max3421e_spi_master.md
MAX3421E_SPI_MASTER -- requirements
Module: max3421e_spi_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2: system clocks per SCLK half-period, legal range 1..255.
REQ-002 SHALL have port clk_in, input, 1: the only clock; all logic on its rising edge.
REQ-003 SHALL have port n_rst_in, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have req_valid_in / req_ready_out, in/out, 1 each: transaction request handshake.
REQ-005 SHALL have reg_in, input, 5: MAX3421E register number.
REQ-006 SHALL have write_in, input, 1: 1 = register write, 0 = register read.
REQ-007 SHALL have len_in, input, 4: data-byte count following the command byte.
REQ-008 SHALL have wdata_in (input, 8), wdata_valid_in (input, 1) and wdata_ready_out (output, 1): write-byte stream.
REQ-009 SHALL have rdata_out (output, 8) and rdata_valid_out (output, 1): read-byte stream with no backpressure.
REQ-010 SHALL have status_out (output, 8) and status_valid_out (output, 1): the byte clocked in during the command byte.
REQ-011 SHALL have busy_out, output, 1: high while a transaction is in progress.
REQ-012 SHALL have n_ss_out, mosi_out and sclk_out, outputs, 1 each, plus miso_in, input, 1: the SPI pins.

Function
REQ-013 SHALL accept a request on the cycle where req_valid_in and req_ready_out are both high, capturing reg_in, write_in and len_in.
REQ-014 SHALL hold req_ready_out high only in IDLE.
REQ-015 SHALL clamp len_in values 9..15 to 8; len 0 SHALL be a command-only (status poll) transaction.
REQ-016 SHALL form the command byte as {reg, 1'b0, write, 1'b0}.
REQ-017 SHALL shift MSB first.
REQ-018 SHALL use SPI mode 0: SCLK idles low, MOSI changes on the falling edge, MISO is sampled on the rising edge.
REQ-019 SHALL run states IDLE -> SETUP -> SHIFT -> (WAIT_WDATA) -> SHIFT ... -> HOLD -> GAP -> IDLE.
REQ-020 SETUP SHALL drive n_ss_out low and present the first bit, then wait one half-period before the first SCLK rise.
REQ-021 SHALL produce exactly 8 SCLK pulses per byte, each high and low for CLK_DIV clocks.
REQ-022 After the command byte it SHALL load status_out and pulse status_valid_out for 1 cycle.
REQ-023 On a write, before each data byte it SHALL assert wdata_ready_out and transfer the byte on valid&&ready.
REQ-024 If wdata_valid_in is low at that point, it SHALL enter WAIT_WDATA with SCLK low and n_ss_out low, and stay there indefinitely.
REQ-025 On a read, MOSI SHALL be 0 during data bytes.
REQ-026 On a read, after each byte's 8th rising edge it SHALL update rdata_out and pulse rdata_valid_out for 1 cycle.
REQ-027 HOLD SHALL keep n_ss_out low for one half-period after the last falling edge.
REQ-028 GAP SHALL keep n_ss_out high for at least 2*CLK_DIV clocks before req_ready_out reasserts.
REQ-029 busy_out SHALL equal !req_ready_out.
REQ-030 A request presented in the same cycle the block returns to IDLE SHALL be accepted that cycle.
REQ-031 Inputs other than the handshakes SHALL be ignored outside the states that use them.
REQ-032 The bit counter SHALL be 3 bits and wrap 7 -> 0 at each byte boundary.
REQ-033 The byte counter SHALL be 4 bits and count down to zero with no underflow.

Reset
REQ-034 While n_rst_in is low, outputs SHALL be immediately: n_ss_out=1, sclk_out=0, mosi_out=0, req_ready_out=0, wdata_ready_out=0, busy_out=0, both valids=0, rdata_out=0, status_out=0.
REQ-035 State SHALL be IDLE after reset, and req_ready_out SHALL rise on the first clock after release.
REQ-036 Reset mid-transaction SHALL abort without completing the current byte; no valid pulse SHALL follow.

Structure
REQ-037 Package max3421e_pkg SHALL hold the state enum, the register-number constants (e.g. RCVFIFO=1, SNDFIFO=2, USBIRQ=13, PINCTL=17, HIRQ=25) and the max-length constant 8.
REQ-038 One sub-module SHALL be natural: spi_clk_gen, a CLK_DIV half-period counter emitting rise/fall strobes.

Verification
REQ-039 Write reg 17, len 1, data 0x18, CLK_DIV=2 -> MOSI bytes 0x8A, 0x18; 16 SCLK pulses of 4 clocks each; n_ss_out low throughout.
REQ-040 Read reg 1, len 3, slave returns status 0x5A then 0x11, 0x22, 0x33 -> status_out=0x5A, followed by three rdata pulses 0x11, 0x22, 0x33.
REQ-041 Write len 2 with wdata_valid_in withheld 50 cycles before byte 2 -> SCLK frozen low, n_ss_out low, and byte 2 correct once supplied.
REQ-042 len_in=0 on reg 25 -> exactly 8 SCLK pulses, one status pulse, no rdata pulses; len_in=12 -> exactly 8 data bytes.
REQ-043 n_rst_in low during bit 4 of a data byte -> n_ss_out=1 and sclk_out=0 within the same cycle, no valid pulse; a new request succeeds after release.
REQ-044 Back-to-back requests held valid -> n_ss_out high for at least 2*CLK_DIV clocks between transactions.
